// File: rtl/shift_left_sequential_if.sv
// Request/response bundle for the sequential left shifter.
interface shift_left_sequential_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic [31:0]      shift_amount;
  logic [WIDTH-1:0] data_out;
  logic             busy;
  logic             done;

  modport master (
    output start, data_in, shift_amount,
    input  data_out, busy, done
  );

  modport slave (
    input  start, data_in, shift_amount,
    output data_out, busy, done
  );
endinterface

// File: rtl/shift_left_sequential.sv
// Multi-cycle logical left shifter: STEP bit positions per clock.
// Optional build macro: SHIFT_LEFT_EARLY_EXIT_EN -- finish early once the
// working register has become all zeros.
module shift_left_sequential #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  shift_left_sequential_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] data_out_q;
  logic             busy_q;
  logic             done_q;

  logic             res_load;
  logic [WIDTH-1:0] res_val;
  logic [WIDTH-1:0] step_work;
  logic [CNT_W-1:0] step_rem;

  // One shift step: full STEP, or the leftover count when fewer remain.
  always_comb begin
    step_work = work_q;
    step_rem  = rem_q;
    if (rem_q >= CNT_W'(STEP)) begin
      step_work = work_q << STEP;
      step_rem  = rem_q - CNT_W'(STEP);
    end else begin
      step_work = work_q << rem_q;
      step_rem  = '0;
    end
  end

  // Next-state and working-register update.
  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    rem_d    = rem_q;
    res_load = 1'b0;
    res_val  = '0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          work_d = bus.data_in;
          if (bus.shift_amount == 32'd0) begin
            state_d  = DONE;
            rem_d    = '0;
            res_load = 1'b1;
            res_val  = bus.data_in;
          end else if (bus.shift_amount >= 32'(WIDTH)) begin
            // Full 32-bit compare so huge counts never alias after truncation.
            state_d  = DONE;
            rem_d    = '0;
            res_load = 1'b1;
            res_val  = '0;
          end else begin
            state_d = SHIFT;
            rem_d   = CNT_W'(bus.shift_amount);
          end
        end
      end
      SHIFT: begin
`ifdef SHIFT_LEFT_EARLY_EXIT_EN
        if (work_q == '0) begin
          state_d  = DONE;
          rem_d    = '0;
          res_load = 1'b1;
          res_val  = '0;
        end else begin
          work_d = step_work;
          rem_d  = step_rem;
          if (step_rem == '0) begin
            state_d  = DONE;
            res_load = 1'b1;
            res_val  = step_work;
          end
        end
`else
        work_d = step_work;
        rem_d  = step_rem;
        if (step_rem == '0) begin
          state_d  = DONE;
          res_load = 1'b1;
          res_val  = step_work;
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, working registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      work_q     <= '0;
      rem_q      <= '0;
      data_out_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
      if (res_load) begin
        data_out_q <= res_val;
      end
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_shift_left_sequential.sv
// Scoreboard bench for shift_left_sequential with STEP=1 and STEP=4 instances.
module tb_shift_left_sequential;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] cyc = 32'd0;
  int          n_checks = 0;
  int          n_fail = 0;
  exp_t        q1[$];
  exp_t        q4[$];
  logic [31:0] last1 = 32'd0;
  logic [31:0] last4 = 32'd0;

  shift_left_sequential_if #(.WIDTH(32)) if1 ();
  shift_left_sequential_if #(.WIDTH(32)) if4 ();

  shift_left_sequential #(.WIDTH(32), .STEP(1)) u_dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (if1.slave)
  );

  shift_left_sequential #(.WIDTH(32), .STEP(4)) u_dut4 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (if4.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 32'd1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Monitors: pop an expectation on every done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && if1.done === 1'b1) begin
      if (q1.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dut1 unexpected done: data_out %h at cycle %0d", if1.data_out, cyc);
      end else begin
        e = q1.pop_front();
        check("dut1 data_out", if1.data_out, e.data);
        check("dut1 done cycle", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && if4.done === 1'b1) begin
      if (q4.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dut4 unexpected done: data_out %h at cycle %0d", if4.data_out, cyc);
      end else begin
        e = q4.pop_front();
        check("dut4 data_out", if4.data_out, e.data);
        check("dut4 done cycle", cyc, e.cyc);
      end
    end
  end

  task automatic issue1(input logic [31:0] d, input logic [31:0] a, input logic [31:0] exp, input int n);
    exp_t e;
    @(negedge clk);
    if1.start = 1'b1;
    if1.data_in = d;
    if1.shift_amount = a;
    e.data = exp;
    e.cyc  = cyc + 32'd1 + 32'(n);
    q1.push_back(e);
    @(negedge clk);
    if1.start = 1'b0;
    if (n > 0) begin
      check("dut1 busy in shift", 32'(if1.busy), 32'd1);
      check("dut1 data_out stable", if1.data_out, last1);
    end
    repeat (n + 1) @(negedge clk);
    check("dut1 busy after done", 32'(if1.busy), 32'd0);
    last1 = exp;
  endtask

  task automatic issue4(input logic [31:0] d, input logic [31:0] a, input logic [31:0] exp, input int n);
    exp_t e;
    @(negedge clk);
    if4.start = 1'b1;
    if4.data_in = d;
    if4.shift_amount = a;
    e.data = exp;
    e.cyc  = cyc + 32'd1 + 32'(n);
    q4.push_back(e);
    @(negedge clk);
    if4.start = 1'b0;
    if (n > 0) begin
      check("dut4 busy in shift", 32'(if4.busy), 32'd1);
      check("dut4 data_out stable", if4.data_out, last4);
    end
    repeat (n + 1) @(negedge clk);
    check("dut4 busy after done", 32'(if4.busy), 32'd0);
    last4 = exp;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    if1.start = 1'b0; if1.data_in = '0; if1.shift_amount = '0;
    if4.start = 1'b0; if4.data_in = '0; if4.shift_amount = '0;
    rst_n = 1'b0;
    #23;
    check("reset data_out", if1.data_out, 32'h0);
    check("reset busy", 32'(if1.busy), 32'd0);
    check("reset done", 32'(if1.done), 32'd0);
    check("reset dut4 data_out", if4.data_out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Zero and out-of-range counts complete immediately.
    issue1(32'hDEAD_BEEF, 32'd0,          32'hDEAD_BEEF, 0);
    issue1(32'hDEAD_BEEF, 32'd32,         32'h0000_0000, 0);
    issue1(32'hDEAD_BEEF, 32'hFFFF_FFFF,  32'h0000_0000, 0);
    issue1(32'hDEAD_BEEF, 32'd33,         32'h0000_0000, 0);

    // Full-length and short single-step shifts.
    issue1(32'h0000_0001, 32'd31, 32'h8000_0000, 31);
    issue1(32'h1234_5678, 32'd4,  32'h2345_6780, 4);
    issue1(32'hA5A5_A5A5, 32'd1,  32'h4B4B_4B4A, 1);

    // Four bits per cycle, including partial final steps.
    issue4(32'h0000_00FF, 32'd6,  32'h0000_3FC0, 2);
    issue4(32'h0000_0001, 32'd7,  32'h0000_0080, 2);
    issue4(32'h0000_0001, 32'd31, 32'h8000_0000, 8);
    issue4(32'hDEAD_BEEF, 32'd32, 32'h0000_0000, 0);

    // Start pulsed during SHIFT is ignored.
    @(negedge clk);
    if1.start = 1'b1; if1.data_in = 32'h0000_0003; if1.shift_amount = 32'd4;
    e.data = 32'h0000_0030; e.cyc = cyc + 32'd5;
    q1.push_back(e);
    @(negedge clk);
    if1.start = 1'b0;
    @(negedge clk);
    if1.start = 1'b1; if1.data_in = 32'hFFFF_FFFF; if1.shift_amount = 32'd1;
    @(negedge clk);
    if1.start = 1'b0;
    check("busy during ignored start", 32'(if1.busy), 32'd1);
    repeat (3) @(negedge clk);
    check("busy after ignored start", 32'(if1.busy), 32'd0);
    last1 = 32'h0000_0030;

    // Reset mid-operation clears outputs asynchronously, no done.
    @(negedge clk);
    if1.start = 1'b1; if1.data_in = 32'h0000_00FF; if1.shift_amount = 32'd8;
    @(negedge clk);
    if1.start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort busy", 32'(if1.busy), 32'd0);
    check("abort done", 32'(if1.done), 32'd0);
    check("abort data_out", if1.data_out, 32'h0);
    check("abort dut4 data_out", if4.data_out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    last1 = 32'h0;
    last4 = 32'h0;
    issue1(32'h0000_0001, 32'd1, 32'h0000_0002, 1);

`ifdef SHIFT_LEFT_EARLY_EXIT_EN
    issue1(32'h8000_0000, 32'd20, 32'h0000_0000, 2);
    issue1(32'h0000_0000, 32'd5,  32'h0000_0000, 1);
`else
    issue1(32'h8000_0000, 32'd20, 32'h0000_0000, 20);
    issue1(32'h0000_0000, 32'd5,  32'h0000_0000, 5);
`endif

    repeat (3) @(negedge clk);
    check("dut1 pending expectations", 32'(q1.size()), 32'd0);
    check("dut4 pending expectations", 32'(q4.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_left_sequential.md
Name: shift_left_sequential

Overview:
Multi-cycle logical left shifter, the left-direction counterpart of the ALU's arithmetic right shifter.
- Captures an operand and shift amount on a start pulse.
- Shifts STEP bit positions per clock, then presents the result with a one-cycle done pulse.
- Serves area-constrained ALU/multiplier datapaths where a full barrel shifter is too large.

Parameters:
WIDTH, 32, operand/result width in bits
STEP, 1, bit positions shifted per SHIFT cycle; power of two, 1..WIDTH

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset; asynchronous assert, active-low
start  input  1  request; sampled only in IDLE
data_in  input  WIDTH  operand, captured with start
shift_amount  input  32  unsigned shift count, captured with start
data_out  output  WIDTH  result; holds last result until next completion
busy  output  1  high in SHIFT and DONE
done  output  1  single-cycle completion strobe

Behaviour:
- Reset: asynchronous on rst_n low, deasserted synchronously into normal operation. On reset: state=IDLE, data_out=0, busy=0, done=0, internal working and remaining registers cleared.
- Reset mid-operation aborts the shift immediately. No done is issued and data_out reads 0.
- States: IDLE, SHIFT, DONE.
- IDLE, start=1 at edge E0: capture data_in into the working register and shift_amount into the remaining count.
  - shift_amount=0: next state DONE, result=data_in.
  - shift_amount>=WIDTH, compared on the full 32 bits: next state DONE, result=0.
  - otherwise: next state SHIFT.
- IDLE, start=0: stay in IDLE.
- SHIFT, each cycle:
  - remaining>=STEP: working<<=STEP, remaining-=STEP.
  - remaining<STEP: working<<=remaining, remaining=0.
  - Vacated LSBs fill with 0.
  - Go to DONE when the updated remaining is 0.
- DONE, one cycle: done=1, busy=1, data_out updated to the result at DONE entry. Next state IDLE unconditionally.
- Latency: done is high in the cycle after edge E0+N, where N = ceil(shift_amount/STEP) for the normal path and N=0 for the 0 and >=WIDTH cases.
- start while busy (SHIFT or DONE) is ignored: it is not queued and the captured operands are unaffected.
- Back-to-back: a new start is accepted in the IDLE cycle after DONE. Minimum issue interval is N+2 cycles.
- data_out changes only on DONE entry or reset. It is stable while busy.
- Width rules:
  - Remaining count is 6 bits for WIDTH=32, i.e. clog2(WIDTH)+1.
  - The >=WIDTH check is done before truncation, so 0xFFFF_FFFF yields result 0 and never aliases to a small count.

Optional Feature:
SHIFT_LEFT_EARLY_EXIT_EN
- Defined: at the start of each SHIFT cycle, if the working register is all zeros, go directly to DONE with result 0, discarding the remaining count. In IDLE, a data_in of 0 with a nonzero, sub-WIDTH amount still enters SHIFT, then exits on the first SHIFT cycle.
- Undefined: SHIFT always runs the full ceil(shift_amount/STEP) cycles, and cycle-exact latency depends only on shift_amount.

Test Plan:
1. STEP=1, data_in=0x0000_0001, shift_amount=31, start at E0 -> 31 SHIFT cycles; done high one cycle after E0+31; data_out=0x8000_0000; busy low afterwards.
2. data_in=0xDEAD_BEEF with shift_amount=0, then shift_amount=32, then shift_amount=0xFFFF_FFFF -> done one cycle after E0 each time; data_out=0xDEAD_BEEF, then 0x0000_0000, then 0x0000_0000.
3. STEP=4, data_in=0x0000_00FF, shift_amount=6 -> 2 SHIFT cycles; done one cycle after E0+2; data_out=0x0000_3FC0.
4. STEP=1, data_in=0x0000_0003, amount 4; second start with data_in=0xFFFF_FFFF, amount 1 pulsed during SHIFT -> ignored; data_out=0x0000_0030; exactly one done pulse.
5. Start with data_in=0x0000_00FF, amount 8; drop rst_n two cycles into SHIFT -> busy, done and data_out go to 0 asynchronously. After release, a fresh start with 0x1, amount 1 -> data_out=0x0000_0002.
6. Macro defined, STEP=1, data_in=0x8000_0000, amount 20 -> done one cycle after E0+2, data_out=0. Macro undefined -> done one cycle after E0+20, data_out=0.
